nbit_branch_predictor: RTL and testbench

NBIT_BRANCH_PREDICTOR -- requirements
Module: nbit_branch_predictor

---
 rtl/bp_pkg.sv | 21 ++
 rtl/bp_sat_ctr.sv | 21 ++
 rtl/nbit_branch_predictor.sv | 126 ++++++++++++
 tb/tb_nbit_branch_predictor.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared constants, BTB entry layout and reset helper for nbit_branch_predictor.
package bp_pkg;

  localparam int unsigned BP_IDX_W_DEF = 6;
  localparam int unsigned BP_CTR_W_DEF = 2;
  localparam int unsigned BP_PC_W      = 32;
  // Widest tag (IDX_W=0); narrower tags are zero-extended into this field.
  localparam int unsigned BP_TAG_MAX_W = 30;

  typedef struct packed {
    logic                    valid;
    logic [BP_TAG_MAX_W-1:0] tag;
    logic [BP_PC_W-1:0]      target;
  } btb_entry_t;

  // Weakly-not-taken value: 2^(ctr_w-1)-1, which is 0 for a 1-bit counter.
  function automatic logic [3:0] ctr_reset_val(input int unsigned ctr_w);
    return 4'((32'd1 << (ctr_w - 32'd1)) - 32'd1);
  endfunction

endpackage

// File: rtl/bp_sat_ctr.sv
// One step of a CTR_W-bit saturating up/down counter.
module bp_sat_ctr #(
  parameter int unsigned CTR_W = 2
) (
  input  logic [CTR_W-1:0] i_ctr,
  input  logic             i_inc,
  output logic [CTR_W-1:0] o_ctr_c
);

  localparam logic [CTR_W-1:0] CTR_MAX = '1;

  always_comb begin
    o_ctr_c = i_ctr;
    if (i_inc) begin
      if (i_ctr != CTR_MAX) o_ctr_c = i_ctr + CTR_W'(1);
    end else begin
      if (i_ctr != '0) o_ctr_c = i_ctr - CTR_W'(1);
    end
  end

endmodule

// File: rtl/nbit_branch_predictor.sv
// Direct-mapped BTB plus saturating-counter direction predictor.
// Define BP_GSHARE_EN for GHR-XOR (gshare) indexing; otherwise bimodal PC indexing.
module nbit_branch_predictor
  import bp_pkg::*;
#(
  parameter int unsigned IDX_W = BP_IDX_W_DEF,
  parameter int unsigned CTR_W = BP_CTR_W_DEF,
  parameter int unsigned GHR_W = IDX_W
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_pred_vld,
  input  logic [31:0]      i_pred_pc,
  output logic             o_pred_taken,
  output logic             o_pred_hit,
  output logic [31:0]      o_pred_target,
  output logic [GHR_W-1:0] o_pred_ghr,
  input  logic             i_upd_vld,
  input  logic [31:0]      i_upd_pc,
  input  logic             i_upd_taken,
  input  logic [31:0]      i_upd_target,
  input  logic             i_upd_mispred,
  input  logic [GHR_W-1:0] i_upd_ghr,
  output logic [31:0]      o_br_cnt,
  output logic [31:0]      o_mispred_cnt
);

  localparam int unsigned      DEPTH   = 1 << IDX_W;
  localparam logic [CTR_W-1:0] CTR_RST = CTR_W'(ctr_reset_val(CTR_W));
  localparam logic [31:0]      CNT_MAX = '1;

  btb_entry_t              r_btb [DEPTH];
  logic [CTR_W-1:0]        r_ctr [DEPTH];
  logic [31:0]             r_br_cnt;
  logic [31:0]             r_mispred_cnt;

  logic [IDX_W-1:0]        w_pred_idx;
  logic [IDX_W-1:0]        w_upd_idx;
  logic [BP_TAG_MAX_W-1:0] w_pred_tag;
  logic [BP_TAG_MAX_W-1:0] w_upd_tag;
  btb_entry_t              w_pred_ent;
  logic [CTR_W-1:0]        w_pred_ctr;
  logic [CTR_W-1:0]        w_ctr_nxt;
  logic                    w_hit;
  logic                    w_taken;
  logic                    w_unused;

  assign w_pred_tag = BP_TAG_MAX_W'(i_pred_pc[31:IDX_W+2]);
  assign w_upd_tag  = BP_TAG_MAX_W'(i_upd_pc[31:IDX_W+2]);

`ifdef BP_GSHARE_EN
  logic [GHR_W-1:0] r_ghr;
  logic [GHR_W-1:0] w_ghr_nxt;

  assign w_pred_idx = i_pred_pc[IDX_W+1:2] ^ IDX_W'(r_ghr);
  assign w_upd_idx  = i_upd_pc[IDX_W+1:2] ^ IDX_W'(i_upd_ghr);
  assign o_pred_ghr = r_ghr;
  assign w_unused   = ^{i_pred_pc[1:0], i_upd_pc[1:0]};

  // Recovery beats speculation; truncating the concat drops the oldest bit (GHR_W=1 safe).
  always_comb begin
    w_ghr_nxt = r_ghr;
    if (i_upd_vld && i_upd_mispred) begin
      w_ghr_nxt = GHR_W'({i_upd_ghr, i_upd_taken});
    end else if (i_pred_vld && w_hit) begin
      w_ghr_nxt = GHR_W'({r_ghr, w_taken});
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) r_ghr <= '0;
    else         r_ghr <= w_ghr_nxt;
  end
`else
  assign w_pred_idx = i_pred_pc[IDX_W+1:2];
  assign w_upd_idx  = i_upd_pc[IDX_W+1:2];
  assign o_pred_ghr = '0;
  assign w_unused   = ^{i_pred_pc[1:0], i_upd_pc[1:0], i_upd_ghr, i_pred_vld};
`endif

  // Same-cycle lookup reads the arrays directly, so it sees pre-update contents.
  assign w_pred_ent    = r_btb[w_pred_idx];
  assign w_pred_ctr    = r_ctr[w_pred_idx];
  assign w_hit         = w_pred_ent.valid && (w_pred_ent.tag == w_pred_tag);
  assign w_taken       = w_hit && w_pred_ctr[CTR_W-1];
  assign o_pred_hit    = w_hit;
  assign o_pred_taken  = w_taken;
  assign o_pred_target = w_pred_ent.target;

  bp_sat_ctr #(
    .CTR_W (CTR_W)
  ) u_sat_ctr (
    .i_ctr   (r_ctr[w_upd_idx]),
    .i_inc   (i_upd_taken),
    .o_ctr_c (w_ctr_nxt)
  );

  // Counter and BTB write-back; only taken outcomes allocate a BTB entry.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_ctr[i] <= CTR_RST;
        r_btb[i] <= '0;
      end
    end else if (i_upd_vld) begin
      r_ctr[w_upd_idx] <= w_ctr_nxt;
      if (i_upd_taken) begin
        r_btb[w_upd_idx] <= '{valid: 1'b1, tag: w_upd_tag, target: i_upd_target};
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_br_cnt      <= '0;
      r_mispred_cnt <= '0;
    end else if (i_upd_vld) begin
      if (r_br_cnt != CNT_MAX) r_br_cnt <= r_br_cnt + 32'd1;
      if (i_upd_mispred && (r_mispred_cnt != CNT_MAX)) r_mispred_cnt <= r_mispred_cnt + 32'd1;
    end
  end

  assign o_br_cnt      = r_br_cnt;
  assign o_mispred_cnt = r_mispred_cnt;

endmodule

// File: tb/tb_nbit_branch_predictor.sv
// Directed vector bench for nbit_branch_predictor (default parameters).
module tb_nbit_branch_predictor;

  logic        clk;
  logic        i_rstn;
  logic        i_pred_vld;
  logic [31:0] i_pred_pc;
  logic        o_pred_taken;
  logic        o_pred_hit;
  logic [31:0] o_pred_target;
  logic [5:0]  o_pred_ghr;
  logic        i_upd_vld;
  logic [31:0] i_upd_pc;
  logic        i_upd_taken;
  logic [31:0] i_upd_target;
  logic        i_upd_mispred;
  logic [5:0]  i_upd_ghr;
  logic [31:0] o_br_cnt;
  logic [31:0] o_mispred_cnt;

  int n_cmp;
  int n_fail;

  nbit_branch_predictor dut (
    .i_clk         (clk),
    .i_rstn        (i_rstn),
    .i_pred_vld    (i_pred_vld),
    .i_pred_pc     (i_pred_pc),
    .o_pred_taken  (o_pred_taken),
    .o_pred_hit    (o_pred_hit),
    .o_pred_target (o_pred_target),
    .o_pred_ghr    (o_pred_ghr),
    .i_upd_vld     (i_upd_vld),
    .i_upd_pc      (i_upd_pc),
    .i_upd_taken   (i_upd_taken),
    .i_upd_target  (i_upd_target),
    .i_upd_mispred (i_upd_mispred),
    .i_upd_ghr     (i_upd_ghr),
    .o_br_cnt      (o_br_cnt),
    .o_mispred_cnt (o_mispred_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        upd_vld;
    logic [31:0] upd_pc;
    logic        upd_tk;
    logic [31:0] upd_tgt;
    logic        upd_mis;
    logic [31:0] pred_pc;
    logic        e_hit;
    logic        e_tk;
    logic        chk_tgt;
    logic [31:0] e_tgt;
    logic [31:0] e_br;
    logic [31:0] e_mis;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic uv, input logic [31:0] upc, input logic utk,
                              input logic [31:0] utgt, input logic umis, input logic [31:0] ppc,
                              input logic ehit, input logic etk, input logic ctgt,
                              input logic [31:0] etgt, input logic [31:0] ebr,
                              input logic [31:0] emis);
    vec_t v;
    v.upd_vld = uv;   v.upd_pc = upc;   v.upd_tk = utk;  v.upd_tgt = utgt;
    v.upd_mis = umis; v.pred_pc = ppc;  v.e_hit = ehit;  v.e_tk = etk;
    v.chk_tgt = ctgt; v.e_tgt = etgt;   v.e_br = ebr;    v.e_mis = emis;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_lookup(input string tag, input logic ehit, input logic etk,
                              input logic [31:0] ebr, input logic [31:0] emis);
    check({tag, ".hit"},   32'(o_pred_hit),   32'(ehit));
    check({tag, ".taken"}, 32'(o_pred_taken), 32'(etk));
    check({tag, ".br"},    o_br_cnt,          ebr);
    check({tag, ".mis"},   o_mispred_cnt,     emis);
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    i_rstn = 1'b0;
    i_pred_vld = 1'b0; i_pred_pc = '0;
    i_upd_vld = 1'b0; i_upd_pc = '0; i_upd_taken = 1'b0;
    i_upd_target = '0; i_upd_mispred = 1'b0; i_upd_ghr = '0;

    // Index 0 is shared by PCs 0x100/0x200/0x300 (tags 1/2/3); 0x104 maps to index 1.
    //              uv  upc        tk  tgt        mis ppc        hit tk ct tgt       br  mis
    vecs[0]  = mk(0, 32'h0,     0, 32'h0,    0, 32'h100, 0, 0, 0, 32'h0,   0,  0);
    vecs[1]  = mk(1, 32'h100,   1, 32'h80,   1, 32'h100, 0, 0, 0, 32'h0,   0,  0);
    vecs[2]  = mk(1, 32'h100,   1, 32'h80,   0, 32'h100, 1, 1, 1, 32'h80,  1,  1);
    vecs[3]  = mk(1, 32'h100,   1, 32'h80,   0, 32'h100, 1, 1, 1, 32'h80,  2,  1);
    vecs[4]  = mk(1, 32'h100,   1, 32'h80,   0, 32'h100, 1, 1, 1, 32'h80,  3,  1);
    vecs[5]  = mk(1, 32'h100,   0, 32'h0,    1, 32'h100, 1, 1, 1, 32'h80,  4,  1);
    vecs[6]  = mk(0, 32'h0,     0, 32'h0,    0, 32'h100, 1, 1, 1, 32'h80,  5,  2);
    vecs[7]  = mk(1, 32'h100,   0, 32'h0,    0, 32'h100, 1, 1, 1, 32'h80,  5,  2);
    vecs[8]  = mk(1, 32'h100,   0, 32'h0,    0, 32'h100, 1, 0, 1, 32'h80,  6,  2);
    vecs[9]  = mk(1, 32'h100,   0, 32'h0,    0, 32'h100, 1, 0, 1, 32'h80,  7,  2);
    vecs[10] = mk(1, 32'h100,   0, 32'h0,    0, 32'h100, 1, 0, 1, 32'h80,  8,  2);
    vecs[11] = mk(1, 32'h100,   0, 32'h0,    0, 32'h100, 1, 0, 1, 32'h80,  9,  2);
    vecs[12] = mk(1, 32'h100,   0, 32'h0,    0, 32'h100, 1, 0, 1, 32'h80,  10, 2);
    vecs[13] = mk(0, 32'h0,     0, 32'h0,    0, 32'h100, 1, 0, 1, 32'h80,  11, 2);
    vecs[14] = mk(1, 32'h200,   1, 32'h240,  1, 32'h100, 1, 0, 1, 32'h80,  11, 2);
    vecs[15] = mk(0, 32'h0,     0, 32'h0,    0, 32'h100, 0, 0, 1, 32'h240, 12, 3);
    vecs[16] = mk(1, 32'h200,   1, 32'h240,  0, 32'h200, 1, 0, 1, 32'h240, 12, 3);
    vecs[17] = mk(0, 32'h0,     0, 32'h0,    0, 32'h200, 1, 1, 1, 32'h240, 13, 3);
    vecs[18] = mk(0, 32'h200,   0, 32'h0,    1, 32'h200, 1, 1, 1, 32'h240, 13, 3);
    vecs[19] = mk(0, 32'h0,     0, 32'h0,    0, 32'h200, 1, 1, 1, 32'h240, 13, 3);
    vecs[20] = mk(1, 32'h300,   0, 32'h999,  0, 32'h200, 1, 1, 1, 32'h240, 13, 3);
    vecs[21] = mk(0, 32'h0,     0, 32'h0,    0, 32'h200, 1, 0, 1, 32'h240, 14, 3);
    vecs[22] = mk(1, 32'h104,   1, 32'h44,   1, 32'h104, 0, 0, 0, 32'h0,   14, 3);
    vecs[23] = mk(0, 32'h0,     0, 32'h0,    0, 32'h104, 1, 1, 1, 32'h44,  15, 4);

    repeat (2) @(negedge clk);
    i_rstn = 1'b1;

    // Each vector: drive after the falling edge, check pre-update state, update on next rise.
    for (int k = 0; k < NV; k++) begin
      @(negedge clk);
      i_pred_vld    = 1'b1;
      i_pred_pc     = vecs[k].pred_pc;
      i_upd_vld     = vecs[k].upd_vld;
      i_upd_pc      = vecs[k].upd_pc;
      i_upd_taken   = vecs[k].upd_tk;
      i_upd_target  = vecs[k].upd_tgt;
      i_upd_mispred = vecs[k].upd_mis;
      #1;
      check_lookup($sformatf("vec%0d", k), vecs[k].e_hit, vecs[k].e_tk, vecs[k].e_br, vecs[k].e_mis);
      if (vecs[k].chk_tgt) check($sformatf("vec%0d.target", k), o_pred_target, vecs[k].e_tgt);
    end

    // Asynchronous reset between edges while an update burst is in flight.
    @(negedge clk);
    i_pred_pc = 32'h200; i_upd_vld = 1'b1; i_upd_pc = 32'h200;
    i_upd_taken = 1'b1; i_upd_target = 32'h240; i_upd_mispred = 1'b1;
    @(posedge clk);
    #2;
    i_rstn = 1'b0;
    #1;
    check_lookup("async_rst", 1'b0, 1'b0, 32'd0, 32'd0);
    check("async_rst.ghr", 32'(o_pred_ghr), 32'd0);
    @(posedge clk);
    @(negedge clk);
    i_rstn = 1'b1;
    i_upd_vld = 1'b0; i_upd_mispred = 1'b0;
    #1;
    check_lookup("post_rst", 1'b0, 1'b0, 32'd0, 32'd0);

    // First update after reset starts from weakly-not-taken (1 -> 2).
    @(negedge clk);
    i_pred_pc = 32'h100; i_upd_vld = 1'b1; i_upd_pc = 32'h100;
    i_upd_taken = 1'b1; i_upd_target = 32'h80; i_upd_mispred = 1'b0;
    @(negedge clk);
    i_upd_vld = 1'b0;
    #1;
    check_lookup("first_upd", 1'b1, 1'b1, 32'd1, 32'd0);
    check("first_upd.target", o_pred_target, 32'h80);

    // Mispredict recovery loads {i_upd_ghr, taken}; bimodal keeps o_pred_ghr at 0.
    @(negedge clk);
    i_pred_vld = 1'b0; i_upd_vld = 1'b1; i_upd_pc = 32'h400; i_upd_taken = 1'b0;
    i_upd_mispred = 1'b1; i_upd_ghr = 6'h15;
    @(negedge clk);
    #1;
`ifdef BP_GSHARE_EN
    check("ghr_recover1", 32'(o_pred_ghr), 32'h2A);
`else
    check("ghr_tied1", 32'(o_pred_ghr), 32'h0);
`endif
    check("ghr_recover1.mis", o_mispred_cnt, 32'd1);
    i_upd_ghr = 6'h05; i_upd_taken = 1'b1; i_upd_target = 32'h480;
    @(negedge clk);
    i_upd_vld = 1'b0; i_upd_mispred = 1'b0;
    #1;
`ifdef BP_GSHARE_EN
    check("ghr_recover2", 32'(o_pred_ghr), 32'h0B);
`else
    check("ghr_tied2", 32'(o_pred_ghr), 32'h0);
`endif
    check("ghr_recover2.mis", o_mispred_cnt, 32'd2);
    check("ghr_recover2.br", o_br_cnt, 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
